// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - ARM condition evaluation, NZCV flag register, write-enable gating and perf counters
module cond_logic #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_valid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             perf_clr,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
  logic             n_f, z_f, c_f, v_f;
  logic             exec;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Only committed flags are used, so an instruction never sees its own ALU result.
  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      4'b0000: CondEx = z_f;
      4'b0001: CondEx = ~z_f;
      4'b0010: CondEx = c_f;
      4'b0011: CondEx = ~c_f;
      4'b0100: CondEx = n_f;
      4'b0101: CondEx = ~n_f;
      4'b0110: CondEx = v_f;
      4'b0111: CondEx = ~v_f;
      4'b1000: CondEx = c_f & ~z_f;
      4'b1001: CondEx = ~c_f | z_f;
      4'b1010: CondEx = (n_f == v_f);
      4'b1011: CondEx = (n_f != v_f);
      4'b1100: CondEx = ~z_f & (n_f == v_f);
      4'b1101: CondEx = z_f | (n_f != v_f);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  assign exec     = instr_valid & CondEx;
  assign PCSrc    = PCS  & exec;
  assign RegWrite = RegW & exec;
  assign MemWrite = MemW & exec;

  always_comb begin
    flags_d = flags_q;
    if (exec && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
    if (exec && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  always_comb begin
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if (perf_clr) begin
      exec_cnt_d = '0;
      skip_cnt_d = '0;
    end else if (exec) begin
      if (exec_cnt_q != '1) exec_cnt_d = exec_cnt_q + 1'b1;
    end else if (instr_valid) begin
      if (skip_cnt_q != '1) skip_cnt_d = skip_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q    <= 4'b0000;
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      flags_q    <= flags_d;
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign Flags    = flags_q;
  assign exec_cnt = exec_cnt_q;
  assign skip_cnt = skip_cnt_q;

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Consumer end of the ALU flag interface.
- Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field of each instruction against the stored flags.
- Gates the decoder's PCS/RegW/MemW requests into the actual write enables. Writes back new flags from the ALU when the instruction executes and requests it.
- Keeps saturating executed/skipped instruction counters for performance observation.
- Sits between the main decoder, the ALU flag outputs, and the register file, data memory and PC mux.

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- instr_valid  input  1  current instruction is real (not a bubble)
- Cond  input  4  instruction condition field [31:28]
- ALUFlags  input  4  ALU flags: [3]=N, [2]=Z, [1]=C, [0]=V
- FlagW  input  2  flag write request: [1] updates N,Z; [0] updates C,V
- PCS  input  1  decoder requests PC write
- RegW  input  1  decoder requests register write
- MemW  input  1  decoder requests memory write
- perf_clr  input  1  synchronous counter clear
- PCSrc  output  1  gated PC write
- RegWrite  output  1  gated register write
- MemWrite  output  1  gated memory write
- CondEx  output  1  condition passed for the current instruction
- Flags  output  4  stored NZCV, same bit order as ALUFlags
- exec_cnt  output  CNT_W  instructions executed
- skip_cnt  output  CNT_W  valid instructions squashed by condition

Behaviour:
- Reset (reset_n low, asynchronous): Flags=4'b0000, exec_cnt=0, skip_cnt=0. Combinational outputs follow from these values.
- Reset mid-operation clears flags and counters immediately. No flag write is committed at the next edge while reset_n is low.
- CondEx is combinational from Cond and the stored Flags only. It never uses ALUFlags, so an instruction sees the flags committed by earlier instructions.
- Condition table:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (never; reserved encoding is squashed)
- Define exec = instr_valid & CondEx.
- Gating (combinational, zero latency): PCSrc=PCS&exec, RegWrite=RegW&exec, MemWrite=MemW&exec.
- Flag update, at the rising edge when exec=1:
  - If FlagW[1]: Flags[3:2] <= ALUFlags[3:2].
  - If FlagW[0]: Flags[1:0] <= ALUFlags[1:0].
  - Each half is independent; an unselected half holds.
- The new flags are visible on Flags and affect CondEx from the cycle after the edge.
- exec=0 never writes flags, whatever FlagW is.
- Counters, evaluated each rising edge in this priority:
  - perf_clr=1: both counters <= 0; the current instruction is not counted.
  - Else if exec: exec_cnt increments.
  - Else if instr_valid & ~CondEx: skip_cnt increments.
  - instr_valid=0: neither counter changes.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Flags are unaffected by perf_clr.

Test Plan:
- Reset, then Cond=0000, instr_valid=1, RegW=1 -> CondEx=0, RegWrite=0. Cond=1110 -> CondEx=1, RegWrite=1.
- Cond=1110, FlagW=2'b11, ALUFlags=4'b0100, one edge -> Flags=4'b0100. Next cycle Cond=0000 with MemW=1 -> MemWrite=1. Cond=0001 -> MemWrite=0.
- Flags=4'b0000, FlagW=2'b10, ALUFlags=4'b1011, exec -> Flags=4'b1000 (C,V held). Then FlagW=2'b01, ALUFlags=4'b0111 -> Flags=4'b1011.
- Flags=4'b1001 (N=1, V=1) -> GE=1, LT=0, GT=1, LE=0. Then Cond=0000 failing, with FlagW=2'b11, ALUFlags=4'b0100 -> Flags stay 4'b1001 and skip_cnt increments by 1.
- CNT_W=4: 20 executed instructions -> exec_cnt=15 (saturated). perf_clr=1 together with an executing instruction -> exec_cnt=0 next cycle. instr_valid=0 with Cond=1110 -> counters and Flags unchanged, all write enables 0.
- Drive reset_n low between clock edges with Flags=4'b1111 -> Flags=0 and counters=0 immediately, before the next clk edge. Release reset -> normal operation resumes.
